// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions: opcode constants, flag bit indices and the memory-stage FSM encoding.
package mem_access_pkg;

   localparam int unsigned OP_W    = 5;
   localparam int unsigned FLAGS_W = 7;
   localparam int unsigned REG_AW  = 5;

   localparam logic [OP_W-1:0] OP_NOP    = 5'd0;
   localparam logic [OP_W-1:0] OP_LOAD   = 5'd20;
   localparam logic [OP_W-1:0] OP_STORE  = 5'd21;
   localparam logic [OP_W-1:0] OP_ABS_LO = 5'd13;
   localparam logic [OP_W-1:0] OP_ABS_HI = 5'd17;

   localparam int unsigned FLAG_OVF     = 0;
   localparam int unsigned FLAG_ABOVE   = 1;
   localparam int unsigned FLAG_EQ      = 2;
   localparam int unsigned FLAG_BELOW   = 3;
   localparam int unsigned FLAG_BETWEEN = 4;
   localparam int unsigned FLAG_COLL    = 5;
   localparam int unsigned FLAG_ERR     = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mem_state_t;

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic is_abs_op(input logic [OP_W-1:0] op);
      return (op >= OP_ABS_LO) && (op <= OP_ABS_HI);
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter bounding how long the memory stage waits for a response.
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   // Saturates at TIMEOUT-1 so a long wait never wraps back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: pass-through for ALU ops, load/store over a valid/ready
// request channel with response timeout, registered writeback bundle.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned AWIDTH  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [DWIDTH-1:0]  in_data,
   input  logic [DWIDTH-1:0]  in_instr,
   input  logic [DWIDTH-1:0]  in_register,
   input  logic [FLAGS_W-1:0] in_flags,
   input  logic               in_reset_regs,
   output logic               stall,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic               mem_we,
   output logic [AWIDTH-1:0]  mem_addr,
   output logic [DWIDTH-1:0]  mem_wdata,
   input  logic               mem_rsp_valid,
   input  logic [DWIDTH-1:0]  mem_rdata,
   output logic               wb_valid,
   output logic               wb_en,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [DWIDTH-1:0]  wb_data,
   output logic [FLAGS_W-1:0] wb_flags,
   output logic               wb_reset_regs
);

   mem_state_t state, state_nxt;

   logic [OP_W-1:0]    opcode_c;
   logic               stall_c, capture_c, pass_c;
   logic               cnt_clear_c, cnt_en_c, rsp_take_c, time_out_c;
   logic               expired;
   logic [REG_AW-1:0]  dest_q;
   logic [FLAGS_W-1:0] flags_q;
   logic               rr_q, err_q;
   logic [DWIDTH-1:0]  rdata_q;
   logic               unused_bits;

   assign opcode_c    = in_instr[31:27];
   assign unused_bits = ^{in_instr[21:0], in_register[DWIDTH-1:AWIDTH]};

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear_c),
      .enable  (cnt_en_c),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      state_nxt   = state;
      stall_c     = 1'b0;
      capture_c   = 1'b0;
      pass_c      = 1'b0;
      cnt_clear_c = 1'b0;
      cnt_en_c    = 1'b0;
      rsp_take_c  = 1'b0;
      time_out_c  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (is_mem_op(opcode_c)) begin
                  capture_c = 1'b1;
                  stall_c   = 1'b1;
                  state_nxt = REQ;
               end else begin
                  pass_c = 1'b1;
               end
            end
         end
         REQ: begin
            stall_c = 1'b1;
            if (mem_req_valid && mem_req_ready) begin
               cnt_clear_c = 1'b1;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            stall_c  = 1'b1;
            cnt_en_c = 1'b1;
            // A response on the final counted cycle still wins over the timeout.
            if (mem_rsp_valid) begin
               rsp_take_c = 1'b1;
               state_nxt  = DONE;
            end else if (expired) begin
               time_out_c = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stall must drop with reset even while execute still presents a memory op.
   assign stall = stall_c & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         dest_q        <= '0;
         flags_q       <= '0;
         rr_q          <= 1'b0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         wb_valid      <= 1'b0;
         wb_en         <= 1'b0;
         wb_addr       <= '0;
         wb_data       <= '0;
         wb_flags      <= '0;
         wb_reset_regs <= 1'b0;
      end else begin
         mem_req_valid <= (state_nxt == REQ);
         if (capture_c) begin
            mem_addr  <= in_register[AWIDTH-1:0];
            mem_we    <= (opcode_c == OP_STORE);
            mem_wdata <= in_data;
            dest_q    <= in_instr[26:22];
            flags_q   <= in_flags;
            rr_q      <= in_reset_regs;
         end
         if (rsp_take_c) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
         end else if (time_out_c) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
         wb_valid <= 1'b0;
         wb_en    <= 1'b0;
         if (pass_c) begin
            wb_valid      <= 1'b1;
            wb_en         <= (opcode_c != OP_NOP);
            wb_addr       <= in_instr[26:22];
            wb_data       <= in_data;
            wb_flags      <= in_flags;
            wb_reset_regs <= in_reset_regs;
         end else if (state == DONE) begin
            wb_valid      <= 1'b1;
            wb_en         <= ~mem_we;
            wb_addr       <= dest_q;
            wb_data       <= mem_we ? '0 : rdata_q;
            wb_flags      <= flags_q | (err_q ? FLAGS_W'(1 << FLAG_ERR) : '0);
            wb_reset_regs <= rr_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table, writeback scoreboard, memory responder model.
module tb_mem_access;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;

   logic          clk, rst;
   logic          in_valid, in_reset_regs;
   logic [DW-1:0] in_data, in_instr, in_register;
   logic [6:0]    in_flags;
   logic          stall, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          wb_valid, wb_en, wb_reset_regs;
   logic [4:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic [6:0]    wb_flags;

   mem_access #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_instr(in_instr),
      .in_register(in_register), .in_flags(in_flags), .in_reset_regs(in_reset_regs),
      .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_flags(wb_flags),
      .wb_reset_regs(wb_reset_regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [31:0] regv;
      logic [6:0]  flags;
      logic        rr;
      logic [31:0] rdata;
      int          ready_wait;
      int          rsp_lat;
      bit          rsp_en;
      logic        exp_en;
      logic [31:0] exp_data;
      logic [6:0]  exp_flags;
      int          exp_stall;
   } vec_t;

   vec_t        vecs[8];
   logic [45:0] sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          wb_count = 0;
   int          n_pushed = 0;

   int          ready_wait = 0;
   int          rsp_lat = 0;
   bit          rsp_en = 1'b0;
   logic [31:0] rdata_val = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: ready after ready_wait REQ cycles, response rsp_lat cycles into WAIT.
   initial begin
      bit acc;
      bit pend;
      int pend_cnt;
      int rdy_cnt;
      acc = 1'b0; pend = 1'b0; pend_cnt = 0; rdy_cnt = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      forever begin
         @(posedge clk);
         acc = mem_req_valid && mem_req_ready && !rst;
         #1;
         mem_rsp_valid = 1'b0;
         if (acc && rsp_en) begin
            pend     = 1'b1;
            pend_cnt = rsp_lat;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rdata     = rdata_val;
               pend          = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (mem_req_valid) begin
            mem_req_ready = (rdy_cnt >= ready_wait);
            rdy_cnt++;
         end else begin
            mem_req_ready = 1'b0;
            rdy_cnt = 0;
         end
      end
   end

   task automatic send(input vec_t v);
      int  stalls;
      bit  done;
      logic we_exp;
      ready_wait = v.ready_wait;
      rsp_lat    = v.rsp_lat;
      rsp_en     = v.rsp_en;
      rdata_val  = v.rdata;
      in_valid      = 1'b1;
      in_instr      = {v.op, v.dest, 22'($urandom)};
      in_data       = v.data;
      in_register   = v.regv;
      in_flags      = v.flags;
      in_reset_regs = v.rr;
      sb_q.push_back({v.exp_en, v.dest, v.exp_data, v.exp_flags, v.rr});
      n_pushed++;
      we_exp = (v.op == 5'd21);
      stalls = 0;
      done   = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (mem_req_valid)
            check("req_fields", 128'({mem_we, mem_addr, mem_wdata}),
                  128'({we_exp, v.regv[15:0], v.data}));
         if (stall) stalls++;
         else       done = 1'b1;
      end
      if (!done) check("stall_release_timeout", 128'(0), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("stall_cycles", 128'(stalls), 128'(v.exp_stall));
   endtask

   initial begin
      int cnt_before;
      vecs[0] = '{op:5'd3,  dest:5'd7,  data:32'h0000_00AA, regv:32'h0,         flags:7'h04, rr:1'b0,
                  rdata:32'h0,         ready_wait:0, rsp_lat:0, rsp_en:1'b0,
                  exp_en:1'b1, exp_data:32'h0000_00AA, exp_flags:7'h04, exp_stall:0};
      vecs[1] = '{op:5'd20, dest:5'd3,  data:32'h0000_0055, regv:32'h0000_1234, flags:7'h02, rr:1'b1,
                  rdata:32'hDEAD_BEEF, ready_wait:0, rsp_lat:0, rsp_en:1'b1,
                  exp_en:1'b1, exp_data:32'hDEAD_BEEF, exp_flags:7'h02, exp_stall:3};
      vecs[2] = '{op:5'd21, dest:5'd9,  data:32'hCAFE_F00D, regv:32'hFFFF_ABCD, flags:7'h11, rr:1'b0,
                  rdata:32'h1111_1111, ready_wait:5, rsp_lat:0, rsp_en:1'b1,
                  exp_en:1'b0, exp_data:32'h0,         exp_flags:7'h11, exp_stall:8};
      vecs[3] = '{op:5'd20, dest:5'd12, data:32'h0,         regv:32'h0000_0040, flags:7'h01, rr:1'b0,
                  rdata:32'h0,         ready_wait:0, rsp_lat:0, rsp_en:1'b0,
                  exp_en:1'b1, exp_data:32'h0,         exp_flags:7'h41, exp_stall:10};
      vecs[4] = '{op:5'd20, dest:5'd31, data:32'h0,         regv:32'h0000_00FF, flags:7'h3F, rr:1'b1,
                  rdata:32'h0BAD_F00D, ready_wait:0, rsp_lat:7, rsp_en:1'b1,
                  exp_en:1'b1, exp_data:32'h0BAD_F00D, exp_flags:7'h3F, exp_stall:10};
      vecs[5] = '{op:5'd0,  dest:5'd4,  data:32'h0000_0123, regv:32'h0,         flags:7'h00, rr:1'b0,
                  rdata:32'h0,         ready_wait:0, rsp_lat:0, rsp_en:1'b0,
                  exp_en:1'b0, exp_data:32'h0000_0123, exp_flags:7'h00, exp_stall:0};
      vecs[6] = '{op:5'd20, dest:5'd5,  data:32'h0,         regv:32'h0000_0010, flags:7'h08, rr:1'b0,
                  rdata:32'h1357_2468, ready_wait:0, rsp_lat:0, rsp_en:1'b1,
                  exp_en:1'b1, exp_data:32'h1357_2468, exp_flags:7'h08, exp_stall:3};
      vecs[7] = '{op:5'd15, dest:5'd6,  data:32'hFFFF_FFFF, regv:32'h0,         flags:7'h08, rr:1'b1,
                  rdata:32'h0,         ready_wait:0, rsp_lat:0, rsp_en:1'b0,
                  exp_en:1'b1, exp_data:32'hFFFF_FFFF, exp_flags:7'h08, exp_stall:0};

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_instr = '0; in_register = '0;
      in_flags = '0; in_reset_regs = 1'b0;

      // Writeback monitor: every wb_valid pulse must match the oldest expected bundle.
      fork
         forever begin
            @(negedge clk);
            if (!rst && wb_valid) begin
               wb_count++;
               if (sb_q.size() == 0) begin
                  check("wb_unexpected", 128'(1), 128'(0));
               end else begin
                  logic [45:0] e;
                  e = sb_q.pop_front();
                  check("wb_bundle", 128'({wb_en, wb_addr, wb_data, wb_flags, wb_reset_regs}), 128'(e));
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check("reset_outputs", 128'({stall, mem_req_valid, mem_we, mem_addr, mem_wdata, wb_valid,
                                   wb_en, wb_addr, wb_data, wb_flags, wb_reset_regs}), 128'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) send(vecs[i]);

      // Reset during WAIT: outputs clear at once and a late response is ignored.
      ready_wait = 0; rsp_lat = 15; rsp_en = 1'b1; rdata_val = 32'h5A5A_5A5A;
      in_valid = 1'b1; in_instr = {5'd20, 5'd2, 22'd0}; in_register = 32'h0000_0001;
      in_data = 32'h0000_7777; in_flags = 7'h05; in_reset_regs = 1'b1;
      repeat (3) @(negedge clk);
      check("wait_state_stall", 128'({stall, mem_req_valid}), 128'(2'b10));
      cnt_before = wb_count;
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 128'({stall, mem_req_valid, mem_we, mem_addr, mem_wdata, wb_valid,
                                         wb_en, wb_addr, wb_data, wb_flags, wb_reset_regs}), 128'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(posedge clk);
      check("no_wb_after_reset", 128'(wb_count), 128'(cnt_before));
      #1;
      send(vecs[0]);

      repeat (3) @(posedge clk);
      check("sb_drain", 128'(sb_q.size()), 128'(0));
      check("wb_pulses", 128'(wb_count), 128'(n_pushed));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
